// File: rtl/tile_sequencer_if.sv
// Control/observation bundle for tile_sequencer: run controls in, beat/row/score view out.
interface tile_sequencer_if #(
  parameter int unsigned ROWS = 8
);
  logic                  clear;
  logic                  run;
  logic [1:0]            speed;
  logic                  beat;
  logic [2:0]            data;
  logic [3*ROWS-1:0]     rows;
  logic [7:0]            tile_cnt;

  modport master (output clear, run, speed, input beat, data, rows, tile_cnt);
  modport slave  (input clear, run, speed, output beat, data, rows, tile_cnt);
endinterface

// File: rtl/tile_sequencer.sv
// Falling-tile note source: beat timer, 8-bit LFSR row generator with no-repeat rule,
// ROWS-deep row shift buffer and saturating count of tiles landing on row 0.
module tile_sequencer #(
  parameter int unsigned BEAT_DIV = 12500000,
  parameter int unsigned ROWS     = 8,
  parameter logic [7:0]  SEED     = 8'hA5
) (
  input  logic           clk,
  input  logic           rst,
  tile_sequencer_if.slave bus
);
  localparam int unsigned RW       = 3 * ROWS;
  localparam logic [7:0]  SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;

  logic [31:0]   cnt_q, cnt_d;
  logic [7:0]    lfsr_q, lfsr_d;
  logic [RW-1:0] rows_q, rows_d;
  logic          beat_q, beat_d;
  logic [7:0]    tile_cnt_q, tile_cnt_d;

  logic [31:0]   period;
  logic          terminal;
  logic [2:0]    cand;
  logic [2:0]    new_row;
  logic          lfsr_fb;

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    cnt_d      = cnt_q;
    lfsr_d     = lfsr_q;
    rows_d     = rows_q;
    beat_d     = 1'b0;
    tile_cnt_d = tile_cnt_q;

    period   = BEAT_DIV >> bus.speed;
    // >= rather than == so shortening the period mid-count fires on the next clock.
    terminal = bus.run && (cnt_q >= period - 32'd1);
    lfsr_fb  = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

    unique case (lfsr_q[1:0])
      2'b00:   cand = 3'b100;
      2'b01:   cand = 3'b010;
      2'b10:   cand = 3'b001;
      default: cand = 3'b000;
    endcase

    // The top row always holds the last generated row, so it is the repeat reference.
    if (cand != 3'b000 && cand == rows_q[RW-1 -: 3]) new_row = {cand[0], cand[2:1]};
    else                                             new_row = cand;

    if (bus.clear) begin
      cnt_d      = '0;
      lfsr_d     = SEED_EFF;
      rows_d     = '0;
      tile_cnt_d = '0;
    end else if (terminal) begin
      cnt_d  = '0;
      beat_d = 1'b1;
      rows_d = {new_row, rows_q[RW-1:3]};
      lfsr_d = {lfsr_q[6:0], lfsr_fb};
      if (rows_q[5:3] != 3'b000 && tile_cnt_q != 8'hFF) tile_cnt_d = tile_cnt_q + 8'd1;
    end else if (bus.run) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q      <= '0;
      lfsr_q     <= SEED_EFF;
      rows_q     <= '0;
      beat_q     <= 1'b0;
      tile_cnt_q <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so all update on the same edge.
      cnt_q      <= cnt_d;
      lfsr_q     <= lfsr_d;
      rows_q     <= rows_d;
      beat_q     <= beat_d;
      tile_cnt_q <= tile_cnt_d;
    end
  end

  assign bus.beat     = beat_q;
  assign bus.rows     = rows_q;
  assign bus.data     = rows_q[2:0];
  assign bus.tile_cnt = tile_cnt_q;
endmodule

// File: tb/tb_tile_sequencer.sv
// Bench for tile_sequencer: two instances (seeds A5 and 01) run in lock-step against a scoreboard.
module tb_tile_sequencer;
  localparam int ROWS = 4;
  localparam int RW   = 3 * ROWS;

  logic clk = 1'b0;
  logic rst;

  tile_sequencer_if #(.ROWS(ROWS)) ifa ();
  tile_sequencer_if #(.ROWS(ROWS)) ifb ();

  tile_sequencer #(.BEAT_DIV(8), .ROWS(ROWS), .SEED(8'hA5)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa)
  );
  tile_sequencer #(.BEAT_DIV(8), .ROWS(ROWS), .SEED(8'h01)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [RW-1:0] rows_a;
    logic [RW-1:0] rows_b;
    logic [7:0]    tile_a;
    logic [7:0]    tile_b;
  } exp_t;

  exp_t          sb[$];
  logic [7:0]    m_lfsr[2];
  logic [RW-1:0] m_rows[2];
  logic [7:0]    m_tile[2];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic c, input logic r, input logic [1:0] s);
    ifa.clear = c; ifa.run = r; ifa.speed = s;
    ifb.clear = c; ifb.run = r; ifb.speed = s;
  endtask

  function automatic logic [2:0] row_of(input logic [1:0] b);
    case (b)
      2'b00:   return 3'b100;
      2'b01:   return 3'b010;
      2'b10:   return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  task automatic model_reset();
    m_lfsr[0] = 8'hA5; m_lfsr[1] = 8'h01;
    for (int d = 0; d < 2; d++) begin
      m_rows[d] = '0;
      m_tile[d] = '0;
    end
    sb.delete();
  endtask

  // Advance the reference by one beat and queue what both DUTs should then show.
  task automatic model_step();
    logic [2:0] cand;
    exp_t       e;
    for (int d = 0; d < 2; d++) begin
      cand = row_of(m_lfsr[d][1:0]);
      if (cand != 3'b000 && cand == m_rows[d][RW-1 -: 3]) cand = {cand[0], cand[2:1]};
      if (m_rows[d][5:3] != 3'b000 && m_tile[d] != 8'hFF) m_tile[d] = m_tile[d] + 8'd1;
      m_rows[d] = {cand, m_rows[d][RW-1:3]};
      m_lfsr[d] = {m_lfsr[d][6:0], m_lfsr[d][7] ^ m_lfsr[d][5] ^ m_lfsr[d][4] ^ m_lfsr[d][3]};
    end
    e.rows_a = m_rows[0]; e.rows_b = m_rows[1];
    e.tile_a = m_tile[0]; e.tile_b = m_tile[1];
    sb.push_back(e);
  endtask

  task automatic wait_beat(input int budget, output int clocks, output bit seen);
    clocks = 0;
    seen   = 1'b0;
    while (clocks < budget && !seen) begin
      @(negedge clk);
      clocks++;
      seen = ifa.beat;
    end
  endtask

  // Wait for the next beat, check its spacing, then pop and compare the scoreboard entry.
  task automatic score_beat(input string name, input int exp_clocks);
    int   clocks;
    bit   seen;
    exp_t e;
    wait_beat(exp_clocks + 20, clocks, seen);
    checks++;
    if (!seen || clocks !== exp_clocks || ifb.beat !== 1'b1) begin
      errors++;
      $display("FAIL %s timing: beat seen=%0b after %0d clocks (beat_b=%b), required after %0d",
               name, seen, clocks, ifb.beat, exp_clocks);
    end
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard: no expected entry queued", name);
    end else begin
      e = sb.pop_front();
      if (ifa.rows !== e.rows_a || ifa.tile_cnt !== e.tile_a || ifa.data !== e.rows_a[2:0] ||
          ifb.rows !== e.rows_b || ifb.tile_cnt !== e.tile_b || ifb.data !== e.rows_b[2:0]) begin
        errors++;
        $display("FAIL %s state: a rows=%b tile=%0d data=%b b rows=%b tile=%0d data=%b; required a rows=%b tile=%0d b rows=%b tile=%0d",
                 name, ifa.rows, ifa.tile_cnt, ifa.data, ifb.rows, ifb.tile_cnt, ifb.data,
                 e.rows_a, e.tile_a, e.rows_b, e.tile_b);
      end
    end
  endtask

  task automatic test_reset();
    checks++;
    if (ifa.beat !== 1'b0 || ifa.rows !== '0 || ifa.data !== 3'b000 || ifa.tile_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_a: beat=%b rows=%b data=%b tile=%0d, required all zero",
               ifa.beat, ifa.rows, ifa.data, ifa.tile_cnt);
    end
    checks++;
    if (ifb.beat !== 1'b0 || ifb.rows !== '0 || ifb.data !== 3'b000 || ifb.tile_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_b: beat=%b rows=%b data=%b tile=%0d, required all zero",
               ifb.beat, ifb.rows, ifb.data, ifb.tile_cnt);
    end
  endtask

  task automatic test_pattern();
    logic [2:0] top_a[4];
    logic [2:0] top_b[4];
    top_a = '{3'b010, 3'b001, 3'b010, 3'b001};
    top_b = '{3'b010, 3'b001, 3'b100, 3'b010};
    model_reset();
    drive(1'b0, 1'b1, 2'd0);
    for (int i = 0; i < 4; i++) begin
      model_step();
      score_beat("pattern", 8);
      checks++;
      if (ifa.rows[RW-1 -: 3] !== top_a[i] || ifb.rows[RW-1 -: 3] !== top_b[i]) begin
        errors++;
        $display("FAIL pattern_top beat %0d: a=%b b=%b, required a=%b b=%b",
                 i + 1, ifa.rows[RW-1 -: 3], ifb.rows[RW-1 -: 3], top_a[i], top_b[i]);
      end
    end
    checks++;
    if (ifa.data !== 3'b010 || ifa.tile_cnt !== 8'd1) begin
      errors++;
      $display("FAIL pattern_beat4: data=%b tile=%0d, required data=010 tile=1", ifa.data, ifa.tile_cnt);
    end
  endtask

  task automatic test_freeze();
    logic [RW-1:0] rows_a, rows_b;
    logic [7:0]    tile_a;
    bit            moved;
    @(negedge clk);
    checks++;
    if (ifa.beat !== 1'b0) begin
      errors++;
      $display("FAIL beat_width: beat=%b one cycle after pulse, required 0", ifa.beat);
    end
    repeat (4) @(negedge clk);
    rows_a = ifa.rows; rows_b = ifb.rows; tile_a = ifa.tile_cnt;
    drive(1'b0, 1'b0, 2'd0);
    moved = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ifa.beat !== 1'b0 || ifa.rows !== rows_a || ifb.rows !== rows_b || ifa.tile_cnt !== tile_a)
        moved = 1'b1;
    end
    checks++;
    if (moved) begin
      errors++;
      $display("FAIL freeze_hold: outputs changed while run=0 (rows_a=%b, required %b)", ifa.rows, rows_a);
    end
    drive(1'b0, 1'b1, 2'd0);
    model_step();
    score_beat("freeze_resume", 3);
  endtask

  task automatic test_speed();
    repeat (5) @(negedge clk);
    drive(1'b0, 1'b1, 2'd1);
    model_step();
    score_beat("speed_short_now", 1);
    model_step();
    score_beat("speed_period4", 4);
    model_step();
    score_beat("speed_period4_again", 4);
    drive(1'b0, 1'b1, 2'd0);
    model_step();
    score_beat("speed_back", 8);
  endtask

  task automatic test_clear();
    repeat (7) @(negedge clk);
    drive(1'b1, 1'b1, 2'd0);
    @(negedge clk);
    checks++;
    if (ifa.beat !== 1'b0 || ifa.rows !== '0 || ifa.tile_cnt !== 8'd0 ||
        ifb.beat !== 1'b0 || ifb.rows !== '0 || ifb.tile_cnt !== 8'd0) begin
      errors++;
      $display("FAIL clear_terminal: beat=%b rows=%b tile=%0d, required beat 0 and reset state",
               ifa.beat, ifa.rows, ifa.tile_cnt);
    end
    drive(1'b0, 1'b1, 2'd0);
    model_reset();
    model_step();
    score_beat("clear_restart", 8);
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      model_step();
      score_beat("pre_reset_run", 8);
    end
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (ifa.rows !== '0 || ifa.data !== 3'b000 || ifa.tile_cnt !== 8'd0 || ifa.beat !== 1'b0 ||
        ifb.rows !== '0 || ifb.tile_cnt !== 8'd0) begin
      errors++;
      $display("FAIL async_reset: rows=%b data=%b tile=%0d beat=%b without a clock, required all zero",
               ifa.rows, ifa.data, ifa.tile_cnt, ifa.beat);
    end
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_saturation();
    logic [7:0] prev_b;
    bit         wrapped;
    prev_b  = 8'd0;
    wrapped = 1'b0;
    drive(1'b0, 1'b1, 2'd2);
    for (int i = 0; i < 450; i++) begin
      model_step();
      score_beat("saturation_run", 2);
      if (ifb.tile_cnt < prev_b) wrapped = 1'b1;
      prev_b = ifb.tile_cnt;
    end
    checks++;
    if (wrapped || ifb.tile_cnt !== 8'd255) begin
      errors++;
      $display("FAIL saturation: tile_cnt=%0d wrapped=%0b, required 255 with no wrap",
               ifb.tile_cnt, wrapped);
    end
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b0, 1'b0, 2'd0);
    repeat (2) @(negedge clk);
    test_reset();
    rst = 1'b1;
    test_pattern();
    test_freeze();
    test_speed();
    test_clear();
    test_async_reset();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
